// File: rtl/pulse_period_meter_pkg.sv
// Shared types and default widths for the pulse period meter.
package pulse_period_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_e;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_DROP_W = 8;

endpackage

// File: rtl/pulse_period_meter_hold.sv
// One-entry valid/ready output register; results arriving while it is full and
// stalled are discarded and counted in a saturating drop counter.
module period_hold_reg
    import pulse_period_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_vld,
    input  logic [CNT_W-1:0]  new_val,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [CNT_W-1:0]  m_period,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    logic              valid_q,  valid_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [DROP_W-1:0] drop_q,   drop_d;

    // Load, hand-off and drop decisions for the holding register.
    always_comb begin
        valid_d  = valid_q;
        period_d = period_q;
        drop_d   = drop_q;
        if (new_vld) begin
            if (!valid_q || m_ready) begin
                valid_d  = 1'b1;
                period_d = new_val;
            end else if (drop_q != DROP_MAX) begin
                drop_d = drop_q + DROP_ONE;
            end else begin
                drop_d = drop_q;
            end
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            period_q <= '0;
            drop_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            period_q <= period_d;
            drop_q   <= drop_d;
        end
    end

    assign m_valid  = valid_q;
    assign m_period = period_q;
    assign drop_cnt = drop_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the fast-clock interval between consecutive synchronised event pulses,
// flags missing pulses with a timeout strobe and buffers results for a sink.
module pulse_period_meter
    import pulse_period_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 60000,
    parameter int DROP_W  = DEF_DROP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              pulse_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  m_period,
    output logic              timeout,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             timeout_q, timeout_d;
    logic             res_vld_s;
    logic [CNT_W-1:0] res_val_s;

    // Next-state, interval counter and result/timeout generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        res_vld_s = 1'b0;
        res_val_s = cnt_q;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    cnt_d   = '0;
                end
                ST_ARM: begin
                    if (pulse_in) begin
                        state_d = ST_MEAS;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_MEAS: begin
                    // A pulse landing on the timeout cycle still yields a result.
                    if (pulse_in) begin
                        res_vld_s = 1'b1;
                        cnt_d     = CNT_ONE;
                    end else if (cnt_q == CNT_TO) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state, counter and timeout strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

    period_hold_reg #(
        .CNT_W  (CNT_W),
        .DROP_W (DROP_W)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .new_vld  (res_vld_s),
        .new_val  (res_val_s),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_period (m_period),
        .drop_cnt (drop_cnt)
    );

endmodule
